// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes, bridge FSM states and a
// response classification helper.
package axil_pkg;

  localparam logic [1:0] AXIL_OKAY   = 2'b00;
  localparam logic [1:0] AXIL_EXOKAY = 2'b01;
  localparam logic [1:0] AXIL_SLVERR = 2'b10;
  localparam logic [1:0] AXIL_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } axil_master_state_t;

  // EXOKAY is not legal on AXI-Lite, so anything other than OKAY is an error.
  function automatic logic axil_resp_is_err(input logic [1:0] resp);
    return resp != AXIL_OKAY;
  endfunction

endpackage

// File: rtl/axil_master_bridge_if.sv
// AXI4-Lite bus bundle between the bridge (master) and an AXI-Lite slave.
interface axil_master_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;

  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;

  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axil_master_bridge.sv
// Single-outstanding command/response to AXI4-Lite master bridge. All AXI
// outputs come straight from registers; cmd_ready is decoded from the state.
module axil_master_bridge
  import axil_pkg::*;
#(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter int         STRB_WIDTH = DATA_WIDTH / 8,
  parameter logic [2:0] PROT       = 3'b000
) (
  input  logic                  aclk,
  input  logic                  aresetn,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,

  axil_master_bridge_if.master  m_axil
);

  axil_master_state_t    state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;

  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;

  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            bready_d  = 1'b1;
            state_d   = WRITE;
          end else begin
            arvalid_d = 1'b1;
            rready_d  = 1'b1;
            state_d   = READ;
          end
        end
      end

      WRITE: begin
        if (awvalid_q && m_axil.awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && m_axil.wready) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        // A B beat that beats AW/W is taken anyway; any channel still
        // pending is dropped so nothing is left asserted in IDLE.
        if (m_axil.bvalid && bready_q) begin
          awvalid_d   = 1'b0;
          wvalid_d    = 1'b0;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = axil_resp_is_err(m_axil.bresp);
          state_d     = RESP;
        end
      end

      READ: begin
        if (arvalid_q && m_axil.arready) begin
          arvalid_d = 1'b0;
        end
        if (m_axil.rvalid && rready_q) begin
          arvalid_d   = 1'b0;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = m_axil.rdata;
          rsp_err_d   = axil_resp_is_err(m_axil.rresp);
          state_d     = RESP;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready      = (state_q == IDLE);
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_err        = rsp_err_q;

  assign m_axil.awaddr  = addr_q;
  assign m_axil.awprot  = PROT;
  assign m_axil.awvalid = awvalid_q;
  assign m_axil.wdata   = wdata_q;
  assign m_axil.wstrb   = wstrb_q;
  assign m_axil.wvalid  = wvalid_q;
  assign m_axil.bready  = bready_q;
  assign m_axil.araddr  = addr_q;
  assign m_axil.arprot  = PROT;
  assign m_axil.arvalid = arvalid_q;
  assign m_axil.rready  = rready_q;

endmodule

// File: tb/tb_axil_master_bridge.sv
// Directed and randomized bench for axil_master_bridge with a delay-configurable
// AXI-Lite memory slave.
`timescale 1ns/1ps
module tb_axil_master_bridge;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  axil_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axil ();

  axil_master_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4), .PROT(3'b000)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_axil(axil)
  );

  int checks = 0;
  int failures = 0;

  // slave configuration
  int         aw_delay, w_delay, b_delay, ar_delay, r_delay;
  logic [1:0] bresp_cfg, rresp_cfg;

  int          aw_wait, w_wait, ar_wait, b_cnt, r_cnt, b_accepts;
  logic        got_aw, got_w, r_pend;
  logic [31:0] aw_addr_cap, wdata_cap, r_addr;
  logic [3:0]  wstrb_cap;
  bit [31:0]   mem [bit [31:0]];

  assign axil.awready = (aw_wait >= aw_delay);
  assign axil.wready  = (w_wait >= w_delay);
  assign axil.arready = (ar_wait >= ar_delay);

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  always @(posedge aclk or negedge aresetn) begin : slave
    logic aw_hs, w_hs, ar_hs;
    logic [31:0] a, d, cur;
    logic [3:0]  s;
    if (!aresetn) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_cnt <= 0; r_cnt <= 0;
      got_aw <= 1'b0; got_w <= 1'b0; r_pend <= 1'b0;
      aw_addr_cap <= '0; wdata_cap <= '0; wstrb_cap <= '0; r_addr <= '0;
      axil.bvalid <= 1'b0; axil.bresp <= 2'b00;
      axil.rvalid <= 1'b0; axil.rresp <= 2'b00; axil.rdata <= '0;
    end else begin
      aw_hs = axil.awvalid && axil.awready;
      w_hs  = axil.wvalid && axil.wready;
      ar_hs = axil.arvalid && axil.arready;
      if (aw_hs) aw_wait <= 0; else if (axil.awvalid) aw_wait <= aw_wait + 1;
      if (w_hs) w_wait <= 0; else if (axil.wvalid) w_wait <= w_wait + 1;
      if (ar_hs) ar_wait <= 0; else if (axil.arvalid) ar_wait <= ar_wait + 1;
      if (aw_hs) aw_addr_cap <= axil.awaddr;
      if (w_hs) begin wdata_cap <= axil.wdata; wstrb_cap <= axil.wstrb; end
      a = aw_hs ? axil.awaddr : aw_addr_cap;
      d = w_hs ? axil.wdata : wdata_cap;
      s = w_hs ? axil.wstrb : wstrb_cap;
      if ((got_aw || aw_hs) && (got_w || w_hs) && !axil.bvalid) begin
        if (b_cnt >= b_delay) begin
          cur = mem.exists(a) ? mem[a] : 32'h0;
          mem[a] = merge(cur, d, s);
          axil.bvalid <= 1'b1; axil.bresp <= bresp_cfg;
          got_aw <= 1'b0; got_w <= 1'b0; b_cnt <= 0;
        end else begin
          got_aw <= 1'b1; got_w <= 1'b1; b_cnt <= b_cnt + 1;
        end
      end else begin
        if (aw_hs) got_aw <= 1'b1;
        if (w_hs) got_w <= 1'b1;
      end
      if (axil.bvalid && axil.bready) begin
        axil.bvalid <= 1'b0;
        b_accepts <= b_accepts + 1;
      end
      if (ar_hs) begin
        if (r_delay == 0) begin
          axil.rvalid <= 1'b1;
          axil.rdata  <= mem.exists(axil.araddr) ? mem[axil.araddr] : 32'h0;
          axil.rresp  <= rresp_cfg;
        end else begin
          r_pend <= 1'b1; r_addr <= axil.araddr; r_cnt <= 1;
        end
      end else if (r_pend) begin
        if (r_cnt >= r_delay) begin
          axil.rvalid <= 1'b1;
          axil.rdata  <= mem.exists(r_addr) ? mem[r_addr] : 32'h0;
          axil.rresp  <= rresp_cfg;
          r_pend <= 1'b0;
        end else r_cnt <= r_cnt + 1;
      end
      if (axil.rvalid && axil.rready) axil.rvalid <= 1'b0;
    end
  end

  // valid/payload stability watcher and valid-cycle counters
  logic        aw_pend, w_pend, ar_pend;
  logic [31:0] aw_hold, w_hold, ar_hold;
  int          viol = 0;
  int          aw_hi = 0, w_hi = 0;

  always @(negedge aclk) begin
    if (!aresetn) begin
      aw_pend <= 1'b0; w_pend <= 1'b0; ar_pend <= 1'b0;
    end else begin
      if (aw_pend && (!axil.awvalid || axil.awaddr !== aw_hold)) viol <= viol + 1;
      if (w_pend && (!axil.wvalid || axil.wdata !== w_hold)) viol <= viol + 1;
      if (ar_pend && (!axil.arvalid || axil.araddr !== ar_hold)) viol <= viol + 1;
      aw_pend <= axil.awvalid && !axil.awready;
      w_pend  <= axil.wvalid && !axil.wready;
      ar_pend <= axil.arvalid && !axil.arready;
      aw_hold <= axil.awaddr; w_hold <= axil.wdata; ar_hold <= axil.araddr;
      aw_hi   <= aw_hi + int'(axil.awvalid);
      w_hi    <= w_hi + int'(axil.wvalid);
    end
  end

  initial b_accepts = 0;

  // Starts at a negedge with the bridge idle; returns at the negedge of cycle 1.
  task automatic issue_cmd(input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    while (!cmd_ready && n < 100) begin @(negedge aclk); n++; end
    checks++;
    if (!cmd_ready) begin
      failures++;
      $display("FAIL cmd_accept: cmd_ready=%b required=1", cmd_ready);
    end
    @(negedge aclk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 200) begin @(negedge aclk); lat++; end
    checks++;
    if (!rsp_valid) begin
      failures++;
      $display("FAIL rsp_timeout: rsp_valid=%b required=1", rsp_valid);
    end
  endtask

  task automatic finish_rsp(input int hold);
    repeat (hold) @(negedge aclk);
    rsp_ready = 1'b1;
    @(negedge aclk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge aclk);
    checks++;
    if ({axil.awvalid, axil.wvalid, axil.bready, axil.arvalid, axil.rready} !== 5'b0) begin
      failures++;
      $display("FAIL reset_axi_valids: got=%b required=00000",
               {axil.awvalid, axil.wvalid, axil.bready, axil.arvalid, axil.rready});
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_rsp: valid=%b err=%b rdata=%h required 0/0/0", rsp_valid, rsp_err, rsp_rdata);
    end
    checks++;
    if (axil.awaddr !== 32'h0 || axil.wdata !== 32'h0 || axil.wstrb !== 4'h0) begin
      failures++;
      $display("FAIL reset_regs: awaddr=%h wdata=%h wstrb=%h required 0", axil.awaddr, axil.wdata, axil.wstrb);
    end
    aresetn = 1'b1;
    @(negedge aclk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_cmd_ready: got=%b required=1", cmd_ready);
    end
  endtask

  task automatic test_zero_wait();
    int lat;
    issue_cmd(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    checks++;
    if (axil.awvalid !== 1'b1 || axil.wvalid !== 1'b1 || axil.awaddr !== 32'h100) begin
      failures++;
      $display("FAIL zw_write_cycle1: awvalid=%b wvalid=%b awaddr=%h required 1/1/00000100",
               axil.awvalid, axil.wvalid, axil.awaddr);
    end
    wait_rsp(lat);
    checks++;
    if (lat !== 3 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL zw_write_rsp: lat=%0d err=%b rdata=%h required 3/0/00000000", lat, rsp_err, rsp_rdata);
    end
    finish_rsp(0);
    issue_cmd(1'b0, 32'h100, 32'h0, 4'h0);
    checks++;
    if (axil.arvalid !== 1'b1 || axil.araddr !== 32'h100) begin
      failures++;
      $display("FAIL zw_read_cycle1: arvalid=%b araddr=%h required 1/00000100", axil.arvalid, axil.araddr);
    end
    wait_rsp(lat);
    checks++;
    if (lat !== 3 || rsp_err !== 1'b0 || rsp_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL zw_read_rsp: lat=%0d err=%b rdata=%h required 3/0/deadbeef", lat, rsp_err, rsp_rdata);
    end
    finish_rsp(0);
  endtask

  task automatic test_aw_delay();
    int lat, aw0, w0, b0, v0;
    aw0 = aw_hi; w0 = w_hi; b0 = b_accepts; v0 = viol;
    aw_delay = 3;
    issue_cmd(1'b1, 32'h104, 32'hCAFEF00D, 4'h3);
    wait_rsp(lat);
    finish_rsp(0);
    aw_delay = 0;
    checks++;
    if (aw_hi - aw0 !== 4 || w_hi - w0 !== 1) begin
      failures++;
      $display("FAIL awdly_valid_cycles: aw=%0d w=%0d required 4/1", aw_hi - aw0, w_hi - w0);
    end
    checks++;
    if (b_accepts - b0 !== 1 || viol !== v0) begin
      failures++;
      $display("FAIL awdly_b_stable: b=%0d viol=%0d required 1/0", b_accepts - b0, viol - v0);
    end
    checks++;
    if (lat !== 6 || rsp_err !== 1'b0 || mem[32'h104] !== 32'h0000F00D) begin
      failures++;
      $display("FAIL awdly_result: lat=%0d err=%b mem=%h required 6/0/0000f00d", lat, rsp_err, mem[32'h104]);
    end
  endtask

  task automatic test_resp_err();
    int lat;
    issue_cmd(1'b1, 32'h200, 32'h12345678, 4'hF);
    wait_rsp(lat);
    finish_rsp(0);
    rresp_cfg = 2'b10;
    issue_cmd(1'b0, 32'h200, 32'h0, 4'h0);
    wait_rsp(lat);
    checks++;
    if (rsp_err !== 1'b1 || rsp_rdata !== 32'h12345678) begin
      failures++;
      $display("FAIL rresp_slverr: err=%b rdata=%h required 1/12345678", rsp_err, rsp_rdata);
    end
    finish_rsp(0);
    rresp_cfg = 2'b01;
    issue_cmd(1'b0, 32'h200, 32'h0, 4'h0);
    wait_rsp(lat);
    checks++;
    if (rsp_err !== 1'b1 || rsp_rdata !== 32'h12345678) begin
      failures++;
      $display("FAIL rresp_exokay: err=%b rdata=%h required 1/12345678", rsp_err, rsp_rdata);
    end
    finish_rsp(0);
    rresp_cfg = 2'b00;
    bresp_cfg = 2'b11;
    issue_cmd(1'b1, 32'h204, 32'hFFFFFFFF, 4'hF);
    wait_rsp(lat);
    checks++;
    if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL bresp_decerr: err=%b rdata=%h required 1/00000000", rsp_err, rsp_rdata);
    end
    finish_rsp(0);
    bresp_cfg = 2'b00;
  endtask

  task automatic test_rsp_hold();
    int lat;
    issue_cmd(1'b0, 32'h100, 32'h0, 4'h0);
    wait_rsp(lat);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0 || cmd_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle%0d: valid=%b rdata=%h err=%b cmd_ready=%b required 1/deadbeef/0/0",
                 i, rsp_valid, rsp_rdata, rsp_err, cmd_ready);
      end
      @(negedge aclk);
    end
    rsp_ready = 1'b1;
    @(negedge aclk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_release: valid=%b cmd_ready=%b required 0/1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    aw_delay = 10; w_delay = 10;
    issue_cmd(1'b1, 32'h180, 32'h55AA55AA, 4'hF);
    checks++;
    if (axil.awvalid !== 1'b1 || cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_pre: awvalid=%b cmd_ready=%b required 1/0", axil.awvalid, cmd_ready);
    end
    #2 aresetn = 1'b0;
    #1;
    checks++;
    if ({axil.awvalid, axil.wvalid, axil.bready, axil.arvalid, axil.rready, rsp_valid} !== 6'b0
        || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_async: valids=%b cmd_ready=%b required 000000/1",
               {axil.awvalid, axil.wvalid, axil.bready, axil.arvalid, axil.rready, rsp_valid}, cmd_ready);
    end
    @(negedge aclk);
    @(negedge aclk);
    aw_delay = 0; w_delay = 0;
    aresetn = 1'b1;
    @(negedge aclk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_cmd_ready: got=%b required=1", cmd_ready);
    end
    issue_cmd(1'b0, 32'h100, 32'h0, 4'h0);
    wait_rsp(lat);
    checks++;
    if (lat !== 3 || rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_read: lat=%0d rdata=%h err=%b required 3/deadbeef/0", lat, rsp_rdata, rsp_err);
    end
    finish_rsp(0);
  endtask

  task automatic test_back_to_back();
    bit [31:0]   ref_mem [bit [31:0]];
    logic        wr, exp_err;
    logic [31:0] addr, data, exp_rdata, cur;
    logic [3:0]  strb;
    int          lat;
    for (int t = 0; t < 100; t++) begin
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
      b_delay  = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
      r_delay  = $urandom_range(0, 3);
      bresp_cfg = 2'($urandom_range(0, 3)); rresp_cfg = 2'($urandom_range(0, 3));
      wr   = 1'($urandom_range(0, 1));
      addr = 32'h300 + 32'($urandom_range(0, 3)) * 4;
      data = $urandom;
      strb = 4'($urandom_range(1, 15));
      if (wr) begin
        cur = ref_mem.exists(addr) ? ref_mem[addr] : 32'h0;
        ref_mem[addr] = merge(cur, data, strb);
        exp_rdata = 32'h0;
        exp_err = (bresp_cfg != 2'b00);
      end else begin
        exp_rdata = ref_mem.exists(addr) ? ref_mem[addr] : 32'h0;
        exp_err = (rresp_cfg != 2'b00);
      end
      issue_cmd(wr, addr, data, strb);
      wait_rsp(lat);
      checks++;
      if (rsp_rdata !== exp_rdata || rsp_err !== exp_err) begin
        failures++;
        $display("FAIL b2b_txn%0d: wr=%b addr=%h rdata=%h err=%b required %h/%b",
                 t, wr, addr, rsp_rdata, rsp_err, exp_rdata, exp_err);
      end
      finish_rsp($urandom_range(0, 2));
    end
    aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;
    bresp_cfg = 2'b00; rresp_cfg = 2'b00;
    @(negedge aclk);
    checks++;
    if (viol !== 0) begin
      failures++;
      $display("FAIL valid_stability: violations=%0d required=0", viol);
    end
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;
    bresp_cfg = 2'b00; rresp_cfg = 2'b00;
    test_reset();
    test_zero_wait();
    test_aw_delay();
    test_resp_err();
    test_rsp_hold();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axil_master_bridge.md
Name: axil_master_bridge

Overview:
Converts a simple single-beat command/response interface into AXI4-Lite master transactions. It is the initiator that drives the team's AXI-Lite slaves, such as the BRAM memory and the GPU register blocks, from the CPU/bootloader side. It keeps one transaction in flight at a time and returns read data plus an error flag through a valid/ready response port.

Parameters:
ADDR_WIDTH, 32, address width of cmd_addr and AXI AW/AR.
DATA_WIDTH, 32, data width, one of 32/64.
STRB_WIDTH, DATA_WIDTH/8, write strobe width.
PROT, 3'b000, constant value driven on awprot/arprot.

Ports:
aclk  in  1  clock
aresetn  in  1  reset, asynchronous, active-low
cmd_valid/cmd_ready  in/out  1/1  command handshake
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  byte address, forwarded unmodified
cmd_wdata/cmd_wstrb  in  DATA_WIDTH/STRB_WIDTH  write payload
rsp_valid/rsp_ready  out/in  1/1  response handshake
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
rsp_err  out  1  1 if BRESP/RRESP != OKAY
m_axil_awaddr/awprot/awvalid/awready  out,out,out,in  ADDR_WIDTH,3,1,1  write address channel
m_axil_wdata/wstrb/wvalid/wready  out,out,out,in  DATA_WIDTH,STRB_WIDTH,1,1  write data channel
m_axil_bresp/bvalid/bready  in,in,out  2,1,1  write response channel
m_axil_araddr/arprot/arvalid/arready  out,out,out,in  ADDR_WIDTH,3,1,1  read address channel
m_axil_rdata/rresp/rvalid/rready  in,in,in,out  DATA_WIDTH,2,1,1  read data channel

Behaviour:
- Reset: aresetn low asynchronously forces IDLE and all of the following to 0: every valid and ready output, rsp_valid, rsp_rdata, rsp_err, the address/data registers, and the aw_done/w_done flags.
- States: IDLE, WRITE, READ, RESP. All AXI outputs are registered.
- cmd_ready = (state == IDLE), combinational from state.
- IDLE, on cmd_valid && cmd_ready, latches addr, wdata and wstrb:
  - Write: next cycle awvalid = wvalid = 1, state WRITE.
  - Read: next cycle arvalid = 1, state READ.
- WRITE:
  - awvalid drops on the cycle after its own awvalid && awready handshake and sets aw_done. W behaves the same way and sets w_done. The two channels are independent; same-cycle or either-order handshakes are all legal.
  - bready = 1 throughout WRITE.
  - On bvalid && bready: capture rsp_err = (bresp != OKAY), set rsp_rdata = 0, go to RESP. A bvalid arriving before both flags are set is still accepted (slave protocol violation tolerated, not checked).
- READ:
  - arvalid is held until arready, then deasserted.
  - rready = 1 throughout READ.
  - On rvalid && rready: capture rdata and rsp_err = (rresp != OKAY), go to RESP.
- Valid stability: valid outputs never deassert before their handshake. addr and data are stable while valid is high.
- RESP: rsp_valid = 1 and rsp_rdata/rsp_err are held stable until rsp_ready. On the handshake, go to IDLE with rsp_valid = 0 on the next cycle.
- Latency with a zero-wait slave (ready always high, response one cycle after handshake): command accept at cycle 0, AXI valid at cycle 1, B/R handshake at cycle 2, rsp_valid at cycle 3. Throughput is one transaction per at least 4 cycles; no pipelining.
- Reset mid-transaction: outstanding AXI transfers are abandoned and the slave is reset with the same aresetn.
- Response codes: EXOKAY (2'b01) is treated as an error, since AXI-Lite does not permit it.

Decomposition:
- Shared package axil_pkg:
  - resp codes AXIL_OKAY = 2'b00, AXIL_EXOKAY = 2'b01, AXIL_SLVERR = 2'b10, AXIL_DECERR = 2'b11;
  - typedef enum logic[1:0] axil_master_state_t {IDLE, WRITE, READ, RESP}.
- No sub-module. The channel logic is small enough to stay in a single module.

Test Plan:
- Zero-wait slave: write addr 0x100, data 0xDEADBEEF, strb 4'hF, then read 0x100 → rsp_rdata = 0xDEADBEEF, rsp_err = 0, rsp_valid at cycle 3 after accept.
- awready delayed 3 cycles, wready immediate → wvalid drops after 1 cycle, awvalid held 4 cycles with awaddr stable, exactly one B accepted.
- Slave returns rresp = 2'b10 with rdata 0x12345678 → rsp_err = 1, rsp_rdata = 0x12345678.
- rsp_ready held low 5 cycles → rsp_valid and rsp_data stable; cmd_ready stays 0; IDLE reached only after the handshake.
- aresetn pulled low while in WRITE with awvalid high → all valids 0 immediately (same cycle, asynchronous); after release, cmd_ready = 1 and a new read completes normally.
- 100 random back-to-back writes/reads with random slave ready and response delays → scoreboard matches, no AXI valid drops without a handshake (assertion).
